// File: rtl/pdp_rdma_split_sched.sv
// Split-width scheduler for the PDP read DMA: validates the split tiling of one cube,
// then issues one command per split while bounding the number of outstanding splits.
module pdp_rdma_split_sched #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = 3
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        op_en_trig,
  input  logic [7:0]  split_num,
  input  logic [9:0]  partial_width_in_first,
  input  logic [9:0]  partial_width_in_mid,
  input  logic [9:0]  partial_width_in_last,
  input  logic [12:0] cube_in_width,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_split_idx,
  output logic [12:0] cmd_width,
  output logic [12:0] cmd_x_offset,
  output logic        cmd_first,
  output logic        cmd_last,
  input  logic        split_done,
  output logic        sched_busy,
  output logic        sched_done,
  output logic        cfg_err,
  output logic        proto_err
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         split_num_q, split_num_d;
  logic [9:0]         first_q, first_d;
  logic [9:0]         mid_q, mid_d;
  logic [9:0]         last_q, last_d;
  logic [12:0]        cube_q, cube_d;
  logic [7:0]         idx_q, idx_d;
  logic [12:0]        xoff_q, xoff_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic               gap_q, gap_d;

  logic [21:0] first_w, mid_w, last_w, cube_w, mid_cnt, total;
  logic        width_ok;
  logic [12:0] width_sel;
  logic        valid_int, is_last, accept, retire;

  // Full 22-bit sum so wide configurations cannot alias onto a matching 13-bit width.
  always_comb begin
    first_w  = {12'd0, first_q} + 22'd1;
    mid_w    = {12'd0, mid_q} + 22'd1;
    last_w   = {12'd0, last_q} + 22'd1;
    cube_w   = {9'd0, cube_q} + 22'd1;
    mid_cnt  = (split_num_q >= 8'd2) ? ({14'd0, split_num_q} - 22'd1) : 22'd0;
    total    = first_w + (mid_cnt * mid_w) + last_w;
    width_ok = (split_num_q == 8'd0) || (total == cube_w);
  end

  always_comb begin
    if (split_num_q == 8'd0) begin
      width_sel = cube_q;
    end else if (idx_q == 8'd0) begin
      width_sel = {3'd0, first_q};
    end else if (idx_q == split_num_q) begin
      width_sel = {3'd0, last_q};
    end else begin
      width_sel = {3'd0, mid_q};
    end
  end

  assign valid_int = (state_q == StIssue) && !gap_q;
  assign is_last   = (idx_q == split_num_q);
  assign accept    = valid_int && cmd_ready;
  assign retire    = split_done && (outst_q != '0);
  assign outst_d   = outst_q + CNT_W'(accept) - CNT_W'(retire);

  always_comb begin
    state_d     = state_q;
    split_num_d = split_num_q;
    first_d     = first_q;
    mid_d       = mid_q;
    last_d      = last_q;
    cube_d      = cube_q;
    idx_d       = idx_q;
    xoff_d      = xoff_q;
    gap_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (op_en_trig) begin
          split_num_d = split_num;
          first_d     = partial_width_in_first;
          mid_d       = partial_width_in_mid;
          last_d      = partial_width_in_last;
          cube_d      = cube_in_width;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (width_ok) begin
          idx_d   = 8'd0;
          xoff_d  = 13'd0;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (accept) begin
          idx_d  = idx_q + 8'd1;
          xoff_d = xoff_q + width_sel + 13'd1;
          if (is_last) begin
            state_d = StDrain;
          end else if (outst_d == CNT_W'(MAX_OUTST)) begin
            state_d = StWait;
          end else begin
            gap_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (retire) state_d = StIssue;
      end
      StDrain: begin
        if (outst_d == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q     <= StIdle;
      split_num_q <= 8'd0;
      first_q     <= 10'd0;
      mid_q       <= 10'd0;
      last_q      <= 10'd0;
      cube_q      <= 13'd0;
      idx_q       <= 8'd0;
      xoff_q      <= 13'd0;
      outst_q     <= '0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      split_num_q <= split_num_d;
      first_q     <= first_d;
      mid_q       <= mid_d;
      last_q      <= last_d;
      cube_q      <= cube_d;
      idx_q       <= idx_d;
      xoff_q      <= xoff_d;
      outst_q     <= outst_d;
      gap_q       <= gap_d;
    end
  end

  // Descriptor fields read as zero whenever no command is offered.
  assign cmd_valid     = valid_int;
  assign cmd_split_idx = valid_int ? idx_q : 8'd0;
  assign cmd_width     = valid_int ? width_sel : 13'd0;
  assign cmd_x_offset  = valid_int ? xoff_q : 13'd0;
  assign cmd_first     = valid_int && (idx_q == 8'd0);
  assign cmd_last      = valid_int && is_last;
  assign sched_busy    = (state_q != StIdle);
  assign sched_done    = (state_q == StDone);
  assign cfg_err       = (state_q == StCheck) && !width_ok;
  assign proto_err     = split_done && (outst_q == '0) && !nvdla_core_rst;

endmodule

// File: tb/tb_pdp_rdma_split_sched.sv
// Randomized bench for pdp_rdma_split_sched: expected descriptors come from the split
// tiling arithmetic, and a transaction-level outstanding count polices the issue window.
module tb_pdp_rdma_split_sched;

  localparam int MaxOutst = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [7:0]  sn_in;
  logic [9:0]  f_in, m_in, l_in;
  logic [12:0] cw_in;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_split_idx;
  logic [12:0] cmd_width, cmd_x_offset;
  logic        cmd_first, cmd_last;
  logic        split_done;
  logic        sched_busy, sched_done, cfg_err, proto_err;

  int vecs = 0;
  int errs = 0;
  int exp_w[256];
  int exp_o[256];

  always #5 clk = ~clk;

  pdp_rdma_split_sched #(.MAX_OUTST(MaxOutst), .CNT_W(3)) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .op_en_trig            (trig),
    .split_num             (sn_in),
    .partial_width_in_first(f_in),
    .partial_width_in_mid  (m_in),
    .partial_width_in_last (l_in),
    .cube_in_width         (cw_in),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_split_idx         (cmd_split_idx),
    .cmd_width             (cmd_width),
    .cmd_x_offset          (cmd_x_offset),
    .cmd_first             (cmd_first),
    .cmd_last              (cmd_last),
    .split_done            (split_done),
    .sched_busy            (sched_busy),
    .sched_done            (sched_done),
    .cfg_err               (cfg_err),
    .proto_err             (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] sn, input logic [9:0] f, m, l, input logic [12:0] cw);
    sn_in = sn; f_in = f; m_in = m; l_in = l; cw_in = cw;
    trig = 1'b1;
    tick();
    trig  = 1'b0;
    sn_in = 8'($urandom); f_in = 10'($urandom); m_in = 10'($urandom);
    l_in  = 10'($urandom); cw_in = 13'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 1'b0; cmd_ready = 1'b1; split_done = 1'b1;
    sn_in = 8'd3; f_in = 10'd5; m_in = 10'd5; l_in = 10'd5; cw_in = 13'd23;
    repeat (2) tick();
    vecs++;
    if ({cmd_valid, cmd_split_idx, cmd_width, cmd_x_offset, cmd_first, cmd_last,
         sched_busy, sched_done, cfg_err, proto_err} !== 45'd0)
      begin errs++; $display("FAIL reset_outputs: got valid=%0b busy=%0b proto=%0b idx=%0d, want all 0",
                             cmd_valid, sched_busy, proto_err, cmd_split_idx); end
    split_done = 1'b0; cmd_ready = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  // Runs one operation from trigger to completion under random ready/retire traffic.
  task automatic run_op(input logic [7:0] sn, input logic [9:0] f, m, l,
                        input logic [12:0] cw, input int rp, input int dp);
    int  total, off, w, nxt, outst;
    bit  bad, seen;
    if (sn == 8'd0) total = int'(cw) + 1;
    else begin
      total = int'(f) + 1 + int'(l) + 1;
      if (sn >= 8'd2) total += (int'(sn) - 1) * (int'(m) + 1);
    end
    bad = (total != int'(cw) + 1);
    off = 0;
    for (int i = 0; i <= int'(sn); i++) begin
      if (sn == 8'd0)          w = int'(cw);
      else if (i == 0)         w = int'(f);
      else if (i == int'(sn))  w = int'(l);
      else                     w = int'(m);
      exp_w[i] = w;
      exp_o[i] = off;
      off = (off + w + 1) % 8192;
    end
    cmd_ready = 1'b0; split_done = 1'b0;
    start(sn, f, m, l, cw);
    vecs++;
    if (cfg_err !== bad || cmd_valid !== 1'b0 || sched_busy !== 1'b1)
      begin errs++; $display("FAIL check_cycle sn=%0d: got cfg_err=%0b valid=%0b busy=%0b, want %0b 0 1",
                             sn, cfg_err, cmd_valid, sched_busy, bad); end
    tick();
    if (bad) begin
      vecs++;
      if (sched_busy !== 1'b0 || cmd_valid !== 1'b0)
        begin errs++; $display("FAIL cfg_err_idle: got busy=%0b valid=%0b, want 0 0", sched_busy, cmd_valid); end
      repeat (4) begin
        tick();
        vecs++;
        if (cmd_valid !== 1'b0 || sched_done !== 1'b0 || cfg_err !== 1'b0)
          begin errs++; $display("FAIL cfg_err_quiet: got valid=%0b done=%0b cfg_err=%0b, want 0 0 0",
                                 cmd_valid, sched_done, cfg_err); end
      end
      return;
    end
    vecs++;
    if (cmd_valid !== 1'b1)
      begin errs++; $display("FAIL first_cmd_latency: got valid=%0b, want 1", cmd_valid); end
    nxt = 0; outst = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
      cmd_ready  = ($urandom_range(0, 99) < rp);
      split_done = (outst > 0) && ($urandom_range(0, 99) < dp);
      #1;
      vecs++;
      if (proto_err !== 1'b0)
        begin errs++; $display("FAIL proto_spurious: got proto_err=%0b, want 0", proto_err); end
      if (sched_done) begin
        seen = 1'b1;
        vecs++;
        if (nxt != int'(sn) + 1 || outst != 0)
          begin errs++; $display("FAIL done_early: got done with %0d issued, %0d outstanding, want %0d, 0",
                                 nxt, outst, int'(sn) + 1); end
      end
      if (cmd_valid) begin
        vecs++;
        if (nxt > int'(sn) || outst >= MaxOutst)
          begin errs++; $display("FAIL window: got valid with %0d issued, %0d outstanding, want <=%0d, <%0d",
                                 nxt, outst, int'(sn), MaxOutst); end
        else if (cmd_split_idx !== 8'(nxt) || cmd_width !== 13'(exp_w[nxt]) ||
                 cmd_x_offset !== 13'(exp_o[nxt]) || cmd_first !== (nxt == 0) ||
                 cmd_last !== (nxt == int'(sn)))
          begin errs++; $display("FAIL cmd%0d: got idx=%0d w=%0d off=%0d f=%0b l=%0b, want idx=%0d w=%0d off=%0d f=%0b l=%0b",
                                 nxt, cmd_split_idx, cmd_width, cmd_x_offset, cmd_first, cmd_last,
                                 nxt, exp_w[nxt], exp_o[nxt], nxt == 0, nxt == int'(sn)); end
        if (cmd_ready) begin nxt++; outst++; end
      end
      if (split_done) outst--;
      tick();
    end
    cmd_ready = 1'b0; split_done = 1'b0;
    vecs++;
    if (!seen) begin errs++; $display("FAIL done_timeout: got no sched_done, want one"); end
    #1;
    vecs++;
    if (sched_busy !== 1'b0 || sched_done !== 1'b0)
      begin errs++; $display("FAIL after_done: got busy=%0b done=%0b, want 0 0", sched_busy, sched_done); end
  endtask

  task automatic test_window();
    int acc;
    logic [40:0] held;
    cmd_ready = 1'b0; split_done = 1'b0;
    start(8'd4, 10'd3, 10'd3, 10'd3, 13'd19);
    tick();
    cmd_ready = 1'b1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cmd_valid && cmd_ready) acc++;
      tick();
    end
    vecs++;
    if (acc != MaxOutst) begin errs++; $display("FAIL window_accepts: got %0d, want %0d", acc, MaxOutst); end
    vecs++;
    if (cmd_valid !== 1'b0 || sched_busy !== 1'b1)
      begin errs++; $display("FAIL window_stall: got valid=%0b busy=%0b, want 0 1", cmd_valid, sched_busy); end
    cmd_ready = 1'b0; split_done = 1'b1;
    tick();
    split_done = 1'b0;
    vecs++;
    if (cmd_valid !== 1'b1 || cmd_split_idx !== 8'd2 || cmd_width !== 13'd3 || cmd_x_offset !== 13'd8)
      begin errs++; $display("FAIL window_resume: got valid=%0b idx=%0d w=%0d off=%0d, want 1 2 3 8",
                             cmd_valid, cmd_split_idx, cmd_width, cmd_x_offset); end
    held = {cmd_valid, cmd_split_idx, cmd_width, cmd_x_offset, cmd_first, cmd_last};
    repeat (5) begin
      tick();
      vecs++;
      if ({cmd_valid, cmd_split_idx, cmd_width, cmd_x_offset, cmd_first, cmd_last} !== held)
        begin errs++; $display("FAIL hold_stable: got idx=%0d w=%0d off=%0d valid=%0b, want idx=2 w=3 off=8 valid=1",
                               cmd_split_idx, cmd_width, cmd_x_offset, cmd_valid); end
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({cmd_valid, sched_busy, cmd_split_idx, cmd_x_offset} !== 23'd0)
      begin errs++; $display("FAIL reset_mid_issue: got valid=%0b busy=%0b, want 0 0", cmd_valid, sched_busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_concurrency();
    cmd_ready = 1'b0; split_done = 1'b0;
    start(8'd3, 10'd2, 10'd2, 10'd2, 13'd11);
    tick();
    cmd_ready = 1'b1;
    tick();
    tick();
    split_done = 1'b1;
    #1;
    vecs++;
    if (cmd_valid !== 1'b1 || cmd_split_idx !== 8'd1 || proto_err !== 1'b0)
      begin errs++; $display("FAIL conc_accept: got valid=%0b idx=%0d proto=%0b, want 1 1 0",
                             cmd_valid, cmd_split_idx, proto_err); end
    tick();
    split_done = 1'b0;
    tick();
    vecs++;
    if (cmd_valid !== 1'b1 || cmd_split_idx !== 8'd2 || cmd_x_offset !== 13'd6)
      begin errs++; $display("FAIL conc_continue: got valid=%0b idx=%0d off=%0d, want 1 2 6",
                             cmd_valid, cmd_split_idx, cmd_x_offset); end
    tick();
    cmd_ready = 1'b0;
    repeat (2) begin
      tick();
      vecs++;
      if (cmd_valid !== 1'b0 || sched_busy !== 1'b1)
        begin errs++; $display("FAIL conc_window_full: got valid=%0b busy=%0b, want 0 1", cmd_valid, sched_busy); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    split_done = 1'b1;
    #1;
    vecs++;
    if (proto_err !== 1'b1 || sched_busy !== 1'b0 || cfg_err !== 1'b0 || sched_done !== 1'b0 || cmd_valid !== 1'b0)
      begin errs++; $display("FAIL proto_idle: got proto=%0b busy=%0b cfg_err=%0b done=%0b, want 1 0 0 0",
                             proto_err, sched_busy, cfg_err, sched_done); end
    tick();
    split_done = 1'b0;
    #1;
    vecs++;
    if (proto_err !== 1'b0 || sched_busy !== 1'b0)
      begin errs++; $display("FAIL proto_pulse: got proto=%0b busy=%0b, want 0 0", proto_err, sched_busy); end
  endtask

  task automatic test_reset_drain();
    cmd_ready = 1'b0; split_done = 1'b0;
    start(8'd1, 10'd4, 10'd0, 10'd4, 13'd9);
    tick();
    cmd_ready = 1'b1;
    tick();
    tick();
    tick();
    cmd_ready = 1'b0; split_done = 1'b1;
    tick();
    split_done = 1'b0;
    vecs++;
    if (sched_busy !== 1'b1 || cmd_valid !== 1'b0 || sched_done !== 1'b0)
      begin errs++; $display("FAIL drain_state: got busy=%0b valid=%0b done=%0b, want 1 0 0",
                             sched_busy, cmd_valid, sched_done); end
    rst = 1'b1; split_done = 1'b1;
    #1;
    vecs++;
    if ({cmd_valid, sched_busy, sched_done, cfg_err, proto_err} !== 5'd0)
      begin errs++; $display("FAIL reset_drain: got valid=%0b busy=%0b done=%0b cfg_err=%0b proto=%0b, want 0",
                             cmd_valid, sched_busy, sched_done, cfg_err, proto_err); end
    tick();
    split_done = 1'b0; rst = 1'b0;
    tick();
    run_op(8'd1, 10'd4, 10'd0, 10'd4, 13'd9, 70, 40);
  endtask

  task automatic test_random();
    logic [7:0]  sn;
    logic [9:0]  f, m, l;
    logic [12:0] cw;
    int tot;
    for (int n = 0; n < 10; n++) begin
      sn = 8'($urandom_range(0, 6));
      f  = 10'($urandom_range(0, 20));
      m  = 10'($urandom_range(0, 20));
      l  = 10'($urandom_range(0, 20));
      if (sn == 8'd0) cw = 13'($urandom_range(0, 300));
      else begin
        tot = int'(f) + 1;
        for (int i = 1; i < int'(sn); i++) tot += int'(m) + 1;
        tot += int'(l) + 1;
        cw = 13'(tot - 1);
        if ($urandom_range(0, 3) == 0) cw = cw + 13'($urandom_range(1, 5));
      end
      run_op(sn, f, m, l, cw, int'($urandom_range(30, 100)), int'($urandom_range(20, 70)));
    end
  endtask

  initial begin
    test_reset();
    run_op(8'd2, 10'd9, 10'd15, 10'd7, 13'd33, 100, 30);
    run_op(8'd0, 10'd0, 10'd0, 10'd0, 13'd99, 80, 30);
    run_op(8'd2, 10'd9, 10'd15, 10'd7, 13'd40, 100, 30);
    // 9*1024 = 9216 aliases to 1024 in 13 bits; must still mismatch
    run_op(8'd8, 10'd1023, 10'd1023, 10'd1023, 13'd1023, 100, 30);
    test_window();
    test_concurrency();
    test_reset_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
